// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master frame sequencer with ss_n setup/hold, SCLK half-period strobes and frame-done pulse.
// Optional back-to-back framing without ss_n gap when SPI_CONT_XFER_EN is defined.
module spi_xfer_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_W     = 12,
   parameter int NUM_SS     = 4,
   parameter int SS_SETUP   = 1,
   parameter int SS_HOLD    = 1,
   localparam int SW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
   localparam int BW = $clog2(DATA_WIDTH) + 1
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              send_data,
   input  logic [1:0]        spi_mode,
   input  logic              spiswai,
   input  logic              mstr,
   input  logic [BAUD_W-1:0] BaudRateDivisor,
   input  logic [SW-1:0]     cs_sel,
   output logic [NUM_SS-1:0] ss_n,
   output logic              tip,
   output logic              receive_data,
   output logic              sclk_lead,
   output logic              sclk_trail,
   output logic [BW-1:0]     bit_cnt
);
   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
   state_t            state;
   logic [BAUD_W-1:0] div, div_cnt, div_in, nd;
   logic [3:0]        cnt;
   logic              odd, no, half_end, end_nxt, mode_valid, start, last;
   logic [NUM_SS-1:0] sel_n;
`ifdef SPI_CONT_XFER_EN
   logic              pend;
`endif
   always_comb begin
      mode_valid = mstr & (spi_mode == 2'b00 | (spi_mode == 2'b01 & ~spiswai));
      start      = send_data & mode_valid;
      div_in     = (BaudRateDivisor == '0) ? BAUD_W'(1) : BaudRateDivisor;
      sel_n      = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (32'(cs_sel) == i) sel_n[i] = 1'b0;
      if (&sel_n) sel_n[0] = 1'b0;
      half_end   = div_cnt == div - 1'b1;
      nd         = half_end ? '0 : div_cnt + 1'b1;
      no         = odd ^ half_end;
      end_nxt    = nd == div - 1'b1;
      last       = sclk_trail & (bit_cnt == BW'(DATA_WIDTH));
   end
   // strobes are registered one cycle ahead so they coincide with the half-period's final cycle
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state        <= IDLE;
         div          <= '0;
         div_cnt      <= '0;
         cnt          <= '0;
         odd          <= 1'b0;
         ss_n         <= '1;
         tip          <= 1'b0;
         receive_data <= 1'b0;
         sclk_lead    <= 1'b0;
         sclk_trail   <= 1'b0;
         bit_cnt      <= '0;
`ifdef SPI_CONT_XFER_EN
         pend         <= 1'b0;
`endif
      end else begin
         receive_data <= 1'b0;
         sclk_lead    <= 1'b0;
         sclk_trail   <= 1'b0;
         if (state != IDLE && !mode_valid) begin
            state   <= IDLE;
            ss_n    <= '1;
            tip     <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            cnt     <= '0;
            odd     <= 1'b0;
`ifdef SPI_CONT_XFER_EN
            pend    <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: if (start) begin
                  div     <= div_in;
                  ss_n    <= sel_n;
                  tip     <= 1'b1;
                  bit_cnt <= '0;
                  cnt     <= '0;
                  div_cnt <= '0;
                  odd     <= 1'b0;
                  if (SS_SETUP == 0) begin
                     state     <= XFER;
                     sclk_lead <= div_in == BAUD_W'(1);
                  end else state <= SETUP;
               end
               SETUP: if (cnt == 4'(SS_SETUP - 1)) begin
                  state     <= XFER;
                  sclk_lead <= div == BAUD_W'(1);
               end else cnt <= cnt + 1'b1;
               XFER: if (last) begin
                  receive_data <= 1'b1;
                  cnt          <= '0;
                  div_cnt      <= '0;
                  odd          <= 1'b0;
                  if (SS_HOLD != 0) begin
                     state <= HOLD;
`ifdef SPI_CONT_XFER_EN
                     pend  <= start;
`endif
                  end
`ifdef SPI_CONT_XFER_EN
                  else if (start) begin
                     div       <= div_in;
                     ss_n      <= sel_n;
                     bit_cnt   <= '0;
                     sclk_lead <= div_in == BAUD_W'(1);
                  end
`endif
                  else begin
                     state <= IDLE;
                     ss_n  <= '1;
                     tip   <= 1'b0;
                  end
               end else begin
                  div_cnt    <= nd;
                  odd        <= no;
                  sclk_lead  <= end_nxt & ~no;
                  sclk_trail <= end_nxt & no;
                  if (end_nxt & no) bit_cnt <= bit_cnt + 1'b1;
               end
               HOLD: if (cnt == 4'(SS_HOLD - 1)) begin
`ifdef SPI_CONT_XFER_EN
                  if (pend | start) begin
                     state     <= XFER;
                     div       <= div_in;
                     ss_n      <= sel_n;
                     bit_cnt   <= '0;
                     pend      <= 1'b0;
                     sclk_lead <= div_in == BAUD_W'(1);
                  end else begin
                     state <= IDLE;
                     ss_n  <= '1;
                     tip   <= 1'b0;
                  end
`else
                  state <= IDLE;
                  ss_n  <= '1;
                  tip   <= 1'b0;
`endif
               end else begin
                  cnt  <= cnt + 1'b1;
`ifdef SPI_CONT_XFER_EN
                  pend <= pend | start;
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed checks of spi_xfer_ctrl framing, strobes, abort, ignore and reset.
module tb_spi_xfer_ctrl;
   logic        PCLK = 1'b0;
   logic        PRESETn, send_data, spiswai, mstr;
   logic [1:0]  spi_mode, cs_sel;
   logic [11:0] BaudRateDivisor;
   logic [3:0]  ss_n, bit_cnt;
   logic        tip, receive_data, sclk_lead, sclk_trail;
   int          n_vec = 0, n_err = 0;
   int          lc, tc, rc, re, bad, cnt_a, cnt_b;
   logic [3:0]  ss_p, bc_p;

   spi_xfer_ctrl #(.DATA_WIDTH(8), .BAUD_W(12), .NUM_SS(4), .SS_SETUP(1), .SS_HOLD(1)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .send_data(send_data), .spi_mode(spi_mode),
      .spiswai(spiswai), .mstr(mstr), .BaudRateDivisor(BaudRateDivisor), .cs_sel(cs_sel),
      .ss_n(ss_n), .tip(tip), .receive_data(receive_data), .sclk_lead(sclk_lead),
      .sclk_trail(sclk_trail), .bit_cnt(bit_cnt)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic start(input logic [11:0] d, input logic [1:0] s);
      BaudRateDivisor = d;
      cs_sel = s;
      send_data = 1'b1;
      tick();
      send_data = 1'b0;
   endtask

   // edge e after the start edge; XFER cycle k = e-1 since SS_SETUP is 1
   task automatic run_frame(input int dv, input int ne, input int pe, output int l, output int t,
                            output int r, output int re_o, output int b, output logic [3:0] sp,
                            output logic [3:0] bp);
      int k, pos;
      logic el, et;
      l = 0; t = 0; r = 0; re_o = 0; b = 0; sp = 'x; bp = 'x;
      for (int e = 1; e <= ne; e++) begin
         tick();
         k = e - 1;
         pos = k % (2 * dv);
         el = (k < 16 * dv) && (pos == dv - 1);
         et = (k < 16 * dv) && (pos == 2 * dv - 1);
         if (sclk_lead !== el || sclk_trail !== et) b++;
         l += int'(sclk_lead);
         t += int'(sclk_trail);
         if (receive_data) begin
            r++;
            if (r == 1) re_o = e;
         end
         if (e == pe) begin
            sp = ss_n;
            bp = bit_cnt;
         end
      end
   endtask

   initial begin
      PRESETn = 1'b0; send_data = 1'b0; spi_mode = 2'b00; spiswai = 1'b0; mstr = 1'b1;
      BaudRateDivisor = 12'd2; cs_sel = 2'd0;
      tick(); tick();
      chk("rst_ss_n", ss_n, 4'hF);
      chk("rst_tip", tip, 0);
      chk("rst_rd", receive_data, 0);
      chk("rst_lead", sclk_lead, 0);
      chk("rst_trail", sclk_trail, 0);
      chk("rst_bit_cnt", bit_cnt, 0);
      PRESETn = 1'b1;
      tick();

      start(12'd2, 2'd2);
      chk("b_ss_n_e0", ss_n, 4'b1011);
      chk("b_tip_e0", tip, 1);
      run_frame(2, 34, 33, lc, tc, rc, re, bad, ss_p, bc_p);
      chk("b_lead_cnt", lc, 8);
      chk("b_trail_cnt", tc, 8);
      chk("b_strobe_pat", bad, 0);
      chk("b_rd_cnt", rc, 1);
      chk("b_rd_edge", re, 33);
      chk("b_hold_ss_n", ss_p, 4'b1011);
      chk("b_hold_bit_cnt", bc_p, 8);
      chk("b_end_ss_n", ss_n, 4'hF);
      chk("b_end_tip", tip, 0);
      chk("b_end_bit_cnt", bit_cnt, 8);

      start(12'd0, 2'd0);
      run_frame(1, 20, 10, lc, tc, rc, re, bad, ss_p, bc_p);
      chk("d0_strobe_pat", bad, 0);
      chk("d0_trail_cnt", tc, 8);
      chk("d0_rd_edge", re, 17);
      chk("d0_rd_cnt", rc, 1);
      chk("d0_mid_ss_n", ss_p, 4'b1110);
      chk("d0_mid_bit_cnt", bc_p, 5);
      chk("d0_end_ss_n", ss_n, 4'hF);

      start(12'd2, 2'd1);
      for (int e = 1; e <= 11; e++) tick();
      chk("ab_pre_bit_cnt", bit_cnt, 2);
      chk("ab_pre_ss_n", ss_n, 4'b1101);
      spi_mode = 2'b01; spiswai = 1'b1;
      tick();
      chk("ab_ss_n", ss_n, 4'hF);
      chk("ab_tip", tip, 0);
      chk("ab_bit_cnt", bit_cnt, 0);
      spi_mode = 2'b00; spiswai = 1'b0;
      rc = 0;
      for (int e = 0; e < 30; e++) begin
         tick();
         rc += int'(receive_data);
      end
      chk("ab_no_rd", rc, 0);

      start(12'd1, 2'd3);
      rc = 0; re = 0; cnt_a = 0;
      for (int e = 1; e <= 30; e++) begin
         send_data = (e == 5);
         tick();
         if (receive_data) begin
            rc++;
            re = e;
         end
         if (e >= 18 && tip) cnt_a++;
      end
      send_data = 1'b0;
      chk("bz_rd_cnt", rc, 1);
      chk("bz_rd_edge", re, 17);
      chk("bz_no_refire", cnt_a, 0);

      start(12'd2, 2'd2);
      for (int e = 1; e <= 7; e++) tick();
      PRESETn = 1'b0;
      tick();
      chk("mr_ss_n", ss_n, 4'hF);
      chk("mr_tip", tip, 0);
      chk("mr_trail", sclk_trail, 0);
      chk("mr_bit_cnt", bit_cnt, 0);
      chk("mr_rd", receive_data, 0);
      PRESETn = 1'b1;
      tick();

      mstr = 1'b0; send_data = 1'b1;
      tick(); tick(); tick();
      chk("m0_ss_n", ss_n, 4'hF);
      chk("m0_tip", tip, 0);
      mstr = 1'b1; spi_mode = 2'b10;
      tick(); tick();
      chk("stop_ss_n", ss_n, 4'hF);
      send_data = 1'b0; spi_mode = 2'b00;
      tick();

`ifdef SPI_CONT_XFER_EN
      BaudRateDivisor = 12'd2; cs_sel = 2'd2; send_data = 1'b1;
      tick();
      rc = 0; cnt_a = 0; cnt_b = 0;
      for (int e = 1; e <= 70; e++) begin
         if (e == 40) send_data = 1'b0;
         tick();
         if (receive_data) begin
            rc++;
            if (rc == 1) cnt_a = e;
            if (rc == 2) cnt_b = e;
         end
         if (e <= 66 && ss_n == 4'hF) bad++;
      end
      chk("cx_rd_cnt", rc, 2);
      chk("cx_rd_gap", cnt_b - cnt_a, 33);
      chk("cx_ss_gap", bad, 0);
      chk("cx_end_ss_n", ss_n, 4'hF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
